// File: rtl/cdc_hs_xfer_pkg.sv
// Shared types and limits for the cdc_hs_xfer req/ack clock-domain crossing.
package cdc_hs_pkg;

   localparam int unsigned SYNC_STAGES_MIN = 2;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DROP = 2'd2
   } src_state_e;

   typedef enum logic [1:0] {
      D_IDLE = 2'd0,
      D_HOLD = 2'd1,
      D_ACK  = 2'd2
   } dst_state_e;

endpackage

// File: rtl/cdc_hs_xfer_if.sv
// Source (clk_i) and destination (clk_o) valid/ready bundle of cdc_hs_xfer.
interface cdc_hs_xfer_if #(
   parameter int unsigned DW = 8
);
   logic          s_valid;
   logic          s_ready;
   logic [DW-1:0] s_data;
   logic          d_valid;
   logic          d_ready;
   logic [DW-1:0] d_data;
   logic          busy_i;

   // environment side: produces source words, consumes destination words
   modport master (
      output s_valid, s_data, d_ready,
      input  s_ready, d_valid, d_data, busy_i
   );

   // crossing block side
   modport slave (
      input  s_valid, s_data, d_ready,
      output s_ready, d_valid, d_data, busy_i
   );
endinterface

// File: rtl/cdc_hs_xfer_sync_bit.sv
// Single-bit multi-flop synchroniser into the receiving clock domain, reset to 0.
module cdc_sync_bit #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rstn,
   input  logic d,
   output logic q
);
   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) sync_q <= '0;
      else       sync_q <= sync_d;
   end

   assign q = sync_q[STAGES-1];
endmodule

// File: rtl/cdc_hs_xfer.sv
// Multi-bit CDC transfer: data parked in a source hold register, only req/ack cross.
// Default build is 4-phase; defining CDC_HS_TWO_PHASE_EN selects the toggle protocol.
module cdc_hs_xfer
   import cdc_hs_pkg::*;
#(
   parameter int unsigned DW          = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic          clk_i,
   input  logic          rstn_i,
   input  logic          clk_o,
   input  logic          rstn_o,
   cdc_hs_xfer_if.slave  bus
);

   if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_bad_stages
      $error("cdc_hs_xfer: SYNC_STAGES must be >= 2");
   end
   if (DW < 1) begin : g_bad_dw
      $error("cdc_hs_xfer: DW must be >= 1");
   end

   logic          req_q, req_d;
   logic          ack_q, ack_d;
   logic          busy_q, busy_d;
   logic [DW-1:0] hold_q, hold_d;
   logic          d_valid_q, d_valid_d;
   logic [DW-1:0] d_data_q, d_data_d;
   logic          req_sync, ack_sync;
   logic          s_ready_c;

   cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_req_sync (
      .clk  (clk_o),
      .rstn (rstn_o),
      .d    (req_q),
      .q    (req_sync)
   );

   cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_ack_sync (
      .clk  (clk_i),
      .rstn (rstn_i),
      .d    (ack_q),
      .q    (ack_sync)
   );

`ifndef CDC_HS_TWO_PHASE_EN
   src_state_e src_q, src_d;
   dst_state_e dst_q, dst_d;

   // source: park the word, raise req, wait for ack, return to zero
   always_comb begin
      src_d     = src_q;
      req_d     = req_q;
      hold_d    = hold_q;
      s_ready_c = 1'b0;
      case (src_q)
         S_IDLE: begin
            s_ready_c = ~ack_sync;
            if (bus.s_valid && s_ready_c) begin
               hold_d = bus.s_data;
               req_d  = 1'b1;
               src_d  = S_REQ;
            end
         end
         S_REQ: begin
            if (ack_sync) begin
               req_d = 1'b0;
               src_d = S_DROP;
            end
         end
         S_DROP: begin
            if (!ack_sync) src_d = S_IDLE;
         end
         default: begin
            req_d = 1'b0;
            src_d = S_IDLE;
         end
      endcase
      busy_d = (src_d != S_IDLE);
   end

   // destination: hold is static while req is high, so sampling it here is safe
   always_comb begin
      dst_d     = dst_q;
      ack_d     = ack_q;
      d_valid_d = d_valid_q;
      d_data_d  = d_data_q;
      case (dst_q)
         D_IDLE: begin
            if (req_sync) begin
               d_data_d  = hold_q;
               d_valid_d = 1'b1;
               dst_d     = D_HOLD;
            end
         end
         D_HOLD: begin
            if (bus.d_ready) begin
               d_valid_d = 1'b0;
               ack_d     = 1'b1;
               dst_d     = D_ACK;
            end
         end
         D_ACK: begin
            if (!req_sync) begin
               ack_d = 1'b0;
               dst_d = D_IDLE;
            end
         end
         default: begin
            ack_d     = 1'b0;
            d_valid_d = 1'b0;
            dst_d     = D_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) src_q <= S_IDLE;
      else         src_q <= src_d;
   end

   always_ff @(posedge clk_o or negedge rstn_o) begin
      if (!rstn_o) dst_q <= D_IDLE;
      else         dst_q <= dst_d;
   end
`else
   // source: toggle req per word; busy until the ack toggle comes back
   always_comb begin
      req_d     = req_q;
      hold_d    = hold_q;
      busy_d    = busy_q;
      s_ready_c = ~busy_q;
      if (busy_q) begin
         if (ack_sync == req_q) busy_d = 1'b0;
      end else if (bus.s_valid) begin
         hold_d = bus.s_data;
         req_d  = ~req_q;
         busy_d = 1'b1;
      end
   end

   // destination: a req/ack mismatch marks a new word; ack toggles on hand-off
   always_comb begin
      ack_d     = ack_q;
      d_valid_d = d_valid_q;
      d_data_d  = d_data_q;
      if (d_valid_q) begin
         if (bus.d_ready) begin
            d_valid_d = 1'b0;
            ack_d     = ~ack_q;
         end
      end else if (req_sync != ack_q) begin
         d_data_d  = hold_q;
         d_valid_d = 1'b1;
      end
   end
`endif

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         req_q  <= 1'b0;
         busy_q <= 1'b0;
         hold_q <= '0;
      end else begin
         req_q  <= req_d;
         busy_q <= busy_d;
         hold_q <= hold_d;
      end
   end

   always_ff @(posedge clk_o or negedge rstn_o) begin
      if (!rstn_o) begin
         ack_q     <= 1'b0;
         d_valid_q <= 1'b0;
         d_data_q  <= '0;
      end else begin
         ack_q     <= ack_d;
         d_valid_q <= d_valid_d;
         d_data_q  <= d_data_d;
      end
   end

   assign bus.s_ready = s_ready_c;
   assign bus.busy_i  = busy_q;
   assign bus.d_valid = d_valid_q;
   assign bus.d_data  = d_data_q;

endmodule

// File: tb/tb_cdc_hs_xfer.sv
// Scoreboard bench for cdc_hs_xfer: in-order word queue model, directed cases plus random streams.
module tb_cdc_hs_xfer;
   localparam int unsigned DW = 32;
   localparam int unsigned SS = 3;

   logic clk_i  = 1'b0;
   logic clk_o  = 1'b0;
   logic rstn_i = 1'b0;
   logic rstn_o = 1'b0;
   int   hp_i   = 3;
   int   hp_o   = 5;

   always #(hp_i) clk_i = ~clk_i;
   always #(hp_o) clk_o = ~clk_o;

   cdc_hs_xfer_if #(.DW(DW)) bus ();

   cdc_hs_xfer #(.DW(DW), .SYNC_STAGES(SS)) dut (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .clk_o  (clk_o),
      .rstn_o (rstn_o),
      .bus    (bus.slave)
   );

   int            total    = 0;
   int            bad      = 0;
   int            tx_cnt   = 0;
   int            rx_cnt   = 0;
   int            dv_cyc   = 0;
   int            rdy_mode = 1;   // 0: hold low, 1: hold high, 2: random
   logic [DW-1:0] exp_q[$];

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // accepted words enter the model queue; a reset drops whatever was in flight
   always @(negedge clk_i) begin
      if (!rstn_i) exp_q.delete();
      else if (bus.s_valid && bus.s_ready) begin
         exp_q.push_back(bus.s_data);
         tx_cnt++;
      end
   end

   // every destination hand-off must match the oldest accepted word
   always @(negedge clk_o) begin
      if (bus.d_valid) dv_cyc++;
      if (rstn_o && bus.d_valid && bus.d_ready) begin
         rx_cnt++;
         if (exp_q.size() == 0) chk("unexpected_word", 1, 0);
         else                   chk("d_data", bus.d_data, exp_q.pop_front());
      end
   end

   initial begin
      bus.d_ready = 1'b1;
      forever begin
         @(posedge clk_o);
         #1;
         if (rdy_mode == 2) bus.d_ready = 1'($urandom_range(0, 1));
         else               bus.d_ready = (rdy_mode == 1);
      end
   end

   task automatic send(input logic [DW-1:0] w);
      bit ok = 1'b0;
      @(posedge clk_i);
      #1;
      bus.s_valid = 1'b1;
      bus.s_data  = w;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk_i);
         if (bus.s_ready) begin
            ok = 1'b1;
            break;
         end
      end
      chk("send_accepted", DW'(ok), 1);
      @(posedge clk_i);
      #1;
      bus.s_valid = 1'b0;
   endtask

   // count clk_i cycles until s_ready returns; busy_i must stay high meanwhile
   task automatic wait_idle(input string nm, output int cyc);
      int bm = 0;
      cyc = 0;
      while (cyc < 8000) begin
         @(negedge clk_i);
         if (bus.s_ready) break;
         cyc++;
         if (!bus.busy_i) bm++;
      end
      chk({nm, "_ready_back"}, DW'(bus.s_ready), 1);
      chk({nm, "_busy_held"}, DW'(bm), 0);
      chk({nm, "_busy_clear"}, DW'(bus.busy_i), 0);
   endtask

   task automatic stream(input string nm, input int hi, input int ho);
      int tx0, rx0, cyc;
      hp_i     = hi;
      hp_o     = ho;
      rdy_mode = 2;
      tx0      = tx_cnt;
      rx0      = rx_cnt;
      for (int n = 0; n < 100; n++) begin
         repeat ($urandom_range(0, 3)) @(posedge clk_i);
         send($urandom);
      end
      wait_idle(nm, cyc);
      chk({nm, "_sent"}, DW'(tx_cnt - tx0), 100);
      chk({nm, "_received"}, DW'(rx_cnt - rx0), 100);
      chk({nm, "_queue_empty"}, DW'(exp_q.size()), 0);
      rdy_mode = 1;
      repeat (3) @(posedge clk_o);
   endtask

   initial begin
      int cyc, dv0, rx0, e1, e2, e3;
      bit got;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;

      // reset state
      #1;
      chk("rst_s_ready", DW'(bus.s_ready), 1);
      chk("rst_busy", DW'(bus.busy_i), 0);
      chk("rst_d_valid", DW'(bus.d_valid), 0);
      chk("rst_d_data", bus.d_data, 0);
      repeat (3) @(posedge clk_o);
      rstn_i = 1'b1;
      rstn_o = 1'b1;
      repeat (3) @(posedge clk_i);

      // basic transfer and round-trip length
      dv0 = dv_cyc;
      rx0 = rx_cnt;
      send(32'hA5);
      wait_idle("basic", cyc);
      repeat (4) @(posedge clk_o);
      chk("basic_dvalid_one_cycle", DW'(dv_cyc - dv0), 1);
      chk("basic_delivered", DW'(rx_cnt - rx0), 1);
`ifdef CDC_HS_TWO_PHASE_EN
      chk("basic_round_trip_short", DW'(cyc <= 14), 1);
`else
      chk("basic_round_trip_long", DW'(cyc >= 17), 1);
`endif

      // backpressure with a blocked second word
      rdy_mode = 0;
      repeat (3) @(posedge clk_o);
      send(32'h3C);
      got = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk_o);
         if (bus.d_valid) begin
            got = 1'b1;
            break;
         end
      end
      chk("bp_dvalid_seen", DW'(got), 1);
      @(posedge clk_i);
      #1;
      bus.s_valid = 1'b1;
      bus.s_data  = 32'hDEAD_BEEF;
      e1 = 0; e2 = 0; e3 = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk_o);
         if (!bus.d_valid)           e1++;
         if (bus.d_data !== 32'h3C)  e2++;
         if (bus.s_ready)            e3++;
      end
      chk("bp_dvalid_held", DW'(e1), 0);
      chk("bp_ddata_held", DW'(e2), 0);
      chk("bp_s_ready_low", DW'(e3), 0);
      @(posedge clk_i);
      #1;
      bus.s_valid = 1'b0;
      rx0 = rx_cnt;
      rdy_mode = 1;
      wait_idle("bp", cyc);
      repeat (4) @(posedge clk_o);
      chk("bp_one_word", DW'(rx_cnt - rx0), 1);

      // s_data churn after acceptance must not leak through
      rx0 = rx_cnt;
      send(32'h11);
      for (int i = 0; i < 4000; i++) begin
         @(posedge clk_i);
         #1;
         bus.s_data = $urandom;
         @(negedge clk_i);
         if (bus.s_ready) break;
      end
      chk("stab_ready_back", DW'(bus.s_ready), 1);
      repeat (4) @(posedge clk_o);
      chk("stab_one_word", DW'(rx_cnt - rx0), 1);

      // both resets mid-flight, then a clean transfer
      rdy_mode = 0;
      repeat (3) @(posedge clk_o);
      send(32'h77);
      repeat (12) @(posedge clk_i);
      chk("mid_busy_before_rst", DW'(bus.busy_i), 1);
      rstn_i = 1'b0;
      rstn_o = 1'b0;
      #1;
      chk("mid_rst_s_ready", DW'(bus.s_ready), 1);
      chk("mid_rst_busy", DW'(bus.busy_i), 0);
      chk("mid_rst_d_valid", DW'(bus.d_valid), 0);
      chk("mid_rst_d_data", bus.d_data, 0);
      rdy_mode = 1;
      repeat (4) @(posedge clk_o);
      repeat (2) @(posedge clk_i);
      #1;
      rstn_i = 1'b1;
      rstn_o = 1'b1;
      repeat (3) @(posedge clk_i);
      rx0 = rx_cnt;
      send(32'h5A);
      wait_idle("post_rst", cyc);
      repeat (4) @(posedge clk_o);
      chk("post_rst_one_word", DW'(rx_cnt - rx0), 1);

      // random streams, source faster then source slower
      stream("fast_to_slow", 3, 5);
      stream("slow_to_fast", 7, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cdc_hs_xfer.md
Name: cdc_hs_xfer

Overview:
- Parametrised multi-bit clock-domain-crossing transfer using a 4-phase req/ack handshake.
- Source side (clk_i) has a valid/ready interface; destination side (clk_o) has a valid/ready interface.
- Data is held stable in a source-domain register for the whole handshake; only req/ack cross through synchronisers.
- Successor to the fixed 8-bit flop-chain synchroniser: adds width/stage parametrisation, a data-stability guarantee, backpressure and an optional 2-phase mode.

Parameters:
- DW, 8, data width in bits (>=1).
- SYNC_STAGES, 2, synchroniser flops per crossing (>=2; smaller values are a compile-time error).

Ports:
- clk_i  in  1  source clock
- rstn_i  in  1  source reset; asynchronous, active-low; clock clk_i
- clk_o  in  1  destination clock
- rstn_o  in  1  destination reset; asynchronous, active-low; clock clk_o
- s_valid  in  1  source word valid (clk_i)
- s_ready  out  1  block can accept a word (clk_i)
- s_data  in  DW  source word (clk_i)
- d_valid  out  1  destination word valid (clk_o)
- d_ready  in  1  downstream accepts the word (clk_o)
- d_data  out  DW  destination word (clk_o)
- busy_i  out  1  transfer in flight, source view (clk_i)

Behaviour:
- Reset values:
  - Source: s_ready=1 once ack_sync=0, busy_i=0, req=0, hold register=0.
  - Destination: d_valid=0, d_data=0, ack=0.
- Source FSM (clk_i):
  - S_IDLE: s_ready = (ack_sync==0). On s_valid&&s_ready: hold<=s_data, req<=1, go to S_REQ.
  - S_REQ: s_ready=0, req=1. When ack_sync==1: req<=0, go to S_DROP.
  - S_DROP: s_ready=0, req=0. When ack_sync==0: go to S_IDLE.
  - busy_i=1 in S_REQ and S_DROP.
- Destination FSM (clk_o):
  - D_IDLE: when req_sync==1: d_data<=hold, d_valid<=1, go to D_HOLD. Sampling hold is safe because hold is static while req=1.
  - D_HOLD: d_valid=1, d_data stable. On d_ready: d_valid<=0, ack<=1, go to D_ACK.
  - D_ACK: ack=1. When req_sync==0: ack<=0, go to D_IDLE.
- req_sync and ack_sync: outputs of SYNC_STAGES-flop synchronisers clocked by the receiving clock. req and ack are driven directly from flops, with no combinational logic before the synchroniser.
- Latency:
  - d_valid rises SYNC_STAGES+1 clk_o edges after the first clk_o edge that samples req=1.
  - s_ready returns after 2*SYNC_STAGES+O(1) edges in each domain plus the d_ready wait.
  - Throughput: one word per full round trip.
- s_data is sampled only on the accepting edge; later changes to s_data are ignored.
- d_ready held low keeps the word at d_data indefinitely; the source stays in S_REQ.
- s_valid asserted while s_ready=0: no effect; the word is not accepted.
- Only one word is ever in flight. No loss, no duplication with both domains out of reset.
- Reset mid-operation:
  - Source reset alone: source returns to S_IDLE. s_ready stays 0 until the destination drains D_ACK (ack_sync falls). Any word in D_HOLD is still delivered.
  - Destination reset alone while source is in S_REQ: destination re-captures the still-held word and presents it again. This is a permitted duplicate.
  - Integration rule: assert both resets together.
- Clock ratio: arbitrary and unrelated; correctness does not depend on frequency ratio.

Optional Feature:
- Macro CDC_HS_TWO_PHASE_EN.
- Defined: toggle (2-phase) protocol.
  - Source: on accept, toggles req and sets busy. busy clears when ack_sync==req.
  - Destination: captures when req_sync!=ack, and toggles ack on d_valid&&d_ready.
  - No return-to-zero phase: round trip is roughly halved.
  - s_ready = !busy.
  - Both resets are mandatory together; single-domain reset may lose or duplicate one word.
- Undefined: 4-phase FSMs as above.
- Ports and parameters are identical in both builds.

Decomposition:
- Package cdc_hs_pkg:
  - src_state_e {S_IDLE,S_REQ,S_DROP}
  - dst_state_e {D_IDLE,D_HOLD,D_ACK}
  - localparam SYNC_STAGES_MIN=2
- Sub-module cdc_sync_bit (parameter STAGES; clk, rstn, d, q; reset value 0). Instantiated twice: for req into clk_o and for ack into clk_i.

Test Plan:
- Basic transfer: clk_i 6ns, clk_o 10ns, SYNC_STAGES=2, d_ready=1; s_data=8'hA5 with s_valid for one accept -> d_data=8'hA5, d_valid high exactly 1 clk_o cycle; s_ready back to 1 after the round trip; busy_i high throughout.
- Backpressure: d_ready=0 for 50 clk_o cycles; 8'h3C sent -> d_valid and d_data=8'h3C held stable all 50 cycles; s_ready=0 throughout; release -> s_ready returns.
- Data stability: change s_data every clk_i cycle after accepting 8'h11 -> destination receives 8'h11 only.
- Stream: DW=32, SYNC_STAGES=3, 100 random words with random s_valid/d_ready, both clock ratios (fast-to-slow and slow-to-fast) -> in-order, no loss, no duplication (scoreboard).
- Reset mid-flight: assert rstn_i and rstn_o together while in S_REQ -> all outputs at reset values within one edge; the next word 8'h5A transfers correctly.
- CDC_HS_TWO_PHASE_EN build: rerun the stream test -> identical scoreboard pass; measured round trip shorter than the 4-phase build.
